// File: rtl/first_signal_logger.sv
// first_signal_logger
//   Consumes the first-signal detector's y[2:0] result bus. It turns each
//   idle-to-nonzero transition into a 2-bit decision code and keeps a
//   saturating win count per code. Each code is also queued in a small FIFO,
//   which a reader drains over a valid/ready handshake.
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   y           detector result: y[0]=a, y[1]=b, y[2]=c, 3'b000 = idle
//   clear       synchronous clear of counters, overflow and FIFO
//   out_valid   FIFO head holds a code
//   out_ready   reader accepts the head this cycle
//   out_code    head code: 0=a, 1=b, 2=c, 3=tie; 0 when empty
//   cnt_a/b/c   saturating win counters per channel
//   cnt_tie     saturating count of multi-hot results
//   fifo_level  current FIFO occupancy, 0..DEPTH
//   overflow    sticky; a decision was dropped on a full FIFO
module first_signal_logger #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       y,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_code,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_tie,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [2:0]       y_q;
  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic             event_c, pop_c, full_c, push_ok_c;
  logic [1:0]       code_c;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n;
  logic [LVL_W-1:0] level_n;
  logic [CNT_W-1:0] cnt_a_n, cnt_b_n, cnt_c_n, cnt_tie_n;
  logic             overflow_n, out_valid_n;
  logic [1:0]       out_code_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Only the idle-to-nonzero transition is a new decision
  assign event_c = (y != 3'b000) && (y_q == 3'b000);
  assign pop_c   = out_valid && out_ready;
  assign full_c  = (fifo_level == LVL_W'(DEPTH));

  // One-hot to channel index; anything multi-hot is a tie
  always_comb begin
    code_c = 2'd3;
    case (y)
      3'b001:  code_c = 2'd0;
      3'b010:  code_c = 2'd1;
      3'b100:  code_c = 2'd2;
      default: code_c = 2'd3;
    endcase
  end

  // Next-state for counters, FIFO bookkeeping and the registered head view
  always_comb begin
    cnt_a_n     = cnt_a;
    cnt_b_n     = cnt_b;
    cnt_c_n     = cnt_c;
    cnt_tie_n   = cnt_tie;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    level_n     = fifo_level;
    overflow_n  = overflow;
    push_ok_c   = 1'b0;
    out_code_n  = 2'd0;
    out_valid_n = 1'b0;

    if (clear) begin
      cnt_a_n    = '0;
      cnt_b_n    = '0;
      cnt_c_n    = '0;
      cnt_tie_n  = '0;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      level_n    = '0;
      overflow_n = 1'b0;
    end else begin
      if (event_c) begin
        case (code_c)
          2'd0:    cnt_a_n   = sat_inc(cnt_a);
          2'd1:    cnt_b_n   = sat_inc(cnt_b);
          2'd2:    cnt_c_n   = sat_inc(cnt_c);
          default: cnt_tie_n = sat_inc(cnt_tie);
        endcase
        // A simultaneous pop frees the slot, so a full FIFO still accepts
        if (!full_c || pop_c) begin
          push_ok_c = 1'b1;
          wr_ptr_n  = wr_ptr + PTR_W'(1);
        end else begin
          overflow_n = 1'b1;
        end
      end
      if (pop_c) rd_ptr_n = rd_ptr + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   level_n = fifo_level + LVL_W'(1);
        2'b01:   level_n = fifo_level - LVL_W'(1);
        default: level_n = fifo_level;
      endcase
    end

    // Head after this edge; bypass the code being written if it lands at the head
    if (level_n != '0) begin
      out_valid_n = 1'b1;
      if (push_ok_c && (wr_ptr == rd_ptr_n)) out_code_n = code_c;
      else                                   out_code_n = mem[rd_ptr_n];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q        <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      cnt_c      <= '0;
      cnt_tie    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_code   <= 2'd0;
    end else begin
      y_q        <= y;
      cnt_a      <= cnt_a_n;
      cnt_b      <= cnt_b_n;
      cnt_c      <= cnt_c_n;
      cnt_tie    <= cnt_tie_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      fifo_level <= level_n;
      overflow   <= overflow_n;
      out_valid  <= out_valid_n;
      out_code   <= out_code_n;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
    end else if (push_ok_c) begin
      mem[wr_ptr] <= code_c;
    end
  end

endmodule

// File: tb/tb_first_signal_logger.sv
// Directed bench for first_signal_logger (DEPTH=4, CNT_W=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_first_signal_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] y;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_tie;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  first_signal_logger #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .y          (y),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .cnt_c      (cnt_c),
    .cnt_tie    (cnt_tie),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int a, input int b, input int c,
                         input int t, input int lvl, input int ovf);
    chk({tag, ".cnt_a"}, int'(cnt_a), a);
    chk({tag, ".cnt_b"}, int'(cnt_b), b);
    chk({tag, ".cnt_c"}, int'(cnt_c), c);
    chk({tag, ".cnt_tie"}, int'(cnt_tie), t);
    chk({tag, ".level"}, int'(fifo_level), lvl);
    chk({tag, ".overflow"}, int'(overflow), ovf);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // One event: y nonzero for a cycle, then idle for a cycle
  task automatic pulse(input logic [2:0] v);
    y = v;
    tick();
    y = 3'b000;
    tick();
  endtask

  initial begin
    logic [2:0] seq4 [4];
    int         exp4 [4];
    seq4[0] = 3'b001; seq4[1] = 3'b010; seq4[2] = 3'b100; seq4[3] = 3'b111;
    exp4[0] = 0;      exp4[1] = 1;      exp4[2] = 2;      exp4[3] = 3;

    rst = 1'b0; y = 3'b000; clear = 1'b0; out_ready = 1'b0;

    // 1. reset, then y=001 held 4 cycles
    tick(); tick(); tick();
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.code", int'(out_code), 0);
    rst = 1'b1;
    y = 3'b001;
    chk("t1.valid_pre", int'(out_valid), 0);
    tick();
    chk("t1.valid", int'(out_valid), 1);
    chk("t1.code", int'(out_code), 0);
    tick(); tick(); tick();
    y = 3'b000;
    tick();
    chk_all("t1", 1, 0, 0, 0, 1, 0);
    out_ready = 1'b1;
    tick();
    chk("t1.drained", int'(fifo_level), 0);

    // 2. 010,000,100,000,110,000 with out_ready=1
    y = 3'b010; tick();
    chk("t2.code_b", int'(out_code), 1);
    chk("t2.valid_b", int'(out_valid), 1);
    y = 3'b000; tick();
    chk("t2.valid_gap", int'(out_valid), 0);
    y = 3'b100; tick();
    chk("t2.code_c", int'(out_code), 2);
    y = 3'b000; tick();
    y = 3'b110; tick();
    chk("t2.code_tie", int'(out_code), 3);
    y = 3'b000; tick();
    chk_all("t2", 1, 1, 1, 1, 0, 0);

    // 3. five events with out_ready=0 overflow a 4-deep FIFO
    do_clear();
    chk_all("clr", 0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    pulse(3'b001); pulse(3'b010); pulse(3'b100); pulse(3'b011); pulse(3'b001);
    chk_all("t3", 2, 1, 1, 1, 4, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3.drain%0d", i), int'(out_code), exp4[i]);
      tick();
    end
    chk("t3.empty", int'(fifo_level), 0);
    chk("t3.valid", int'(out_valid), 0);
    chk("t3.ovf_sticky", int'(overflow), 1);

    // 4. full FIFO, event coincides with a pop
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(seq4[i]);
    chk("t4.full", int'(fifo_level), 4);
    y = 3'b010; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; y = 3'b000;
    chk("t4.level", int'(fifo_level), 4);
    chk("t4.ovf", int'(overflow), 0);
    chk("t4.head", int'(out_code), 1);
    chk("t4.cnt_b", int'(cnt_b), 2);
    tick();
    out_ready = 1'b1;
    chk("t4.drain0", int'(out_code), 1); tick();
    chk("t4.drain1", int'(out_code), 2); tick();
    chk("t4.drain2", int'(out_code), 3); tick();
    chk("t4.tail", int'(out_code), 1);   tick();
    chk("t4.empty", int'(fifo_level), 0);

    // 5. saturation, then clear concurrent with an event
    do_clear();
    for (int i = 0; i < 260; i++) pulse(3'b001);
    chk("t5.sat", int'(cnt_a), 255);
    out_ready = 1'b0;
    pulse(3'b010);
    chk("t5.lvl_pre", int'(fifo_level), 1);
    chk("t5.sat_hold", int'(cnt_a), 255);
    y = 3'b001; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_all("t5.clr", 0, 0, 0, 0, 0, 0);
    chk("t5.valid", int'(out_valid), 0);
    tick();
    chk("t5.held_no_evt", int'(cnt_a), 0);
    y = 3'b000; tick();

    // 6. reset pulsed mid-drain with y=100 held
    pulse(3'b100);
    y = 3'b100; tick();
    chk("t6.lvl2", int'(fifo_level), 2);
    out_ready = 1'b1; tick();
    chk("t6.lvl1", int'(fifo_level), 1);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_all("t6.async", 0, 0, 0, 0, 0, 0);
    chk("t6.valid", int'(out_valid), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_all("t6.post", 0, 0, 1, 0, 1, 0);
    chk("t6.code", int'(out_code), 2);
    tick();
    chk("t6.no_repeat", int'(cnt_c), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
